// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small transmit FIFO.
// It sits beside the data RAM and shares the core's address, store data and
// load/store strobes.
//   TXDATA (BASE_ADDR+0): a store pushes write_data[7:0]. A load returns 0.
//   STATUS (BASE_ADDR+4): a load returns {28'b0, overflow, full, empty, busy}.
//                         A store with write_data[3]=1 clears overflow.
// Ports:
//   CLK        system clock, rising edge
//   reset      asynchronous, active-high reset
//   addr       byte address; only addr[31:2] is decoded
//   write_data store data
//   memread    load strobe
//   memwrite   store strobe
//   read_data  status word on a STATUS load, otherwise 0
//   tx         serial output, idle high, driven from a flop
//   busy       a frame is in progress or bytes are still queued
module mmio_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        memread,
   input  logic        memwrite,
   output logic [31:0] read_data,
   output logic        tx,
   output logic        busy
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [29:0]       TXDATA_WORD = BASE_ADDR[31:2];
   localparam logic [29:0]       STATUS_WORD = BASE_ADDR[31:2] + 30'd1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // Address decode and bus strobes
   logic hit_txdata, hit_status;
   logic full, empty;
   logic push, pop, ovf_set, ovf_clr;

   assign hit_txdata = (addr[31:2] == TXDATA_WORD);
   assign hit_status = (addr[31:2] == STATUS_WORD);
   // A store while full is dropped even if a pop happens on the same edge,
   // because full comes from the registered count.
   assign push    = memwrite & hit_txdata & ~full;
   assign ovf_set = memwrite & hit_txdata & full;
   assign ovf_clr = memwrite & hit_status & write_data[3];

   // Byte-lane and alignment bits that the register window never looks at
   logic unused_bits;
   assign unused_bits = ^{addr[1:0], write_data[31:8]};

   // Transmit FIFO
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;
   logic [7:0]       head;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= write_data[7:0];
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (ovf_set)      ovf_q <= 1'b1;
         else if (ovf_clr) ovf_q <= 1'b0;
      end
   end

   // Serialiser FSM
   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              baud_end;

   assign baud_end = (baud_q == BAUD_LAST);

   // State register
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

   // The shift register holds only payload, so it needs no reset
   always_ff @(posedge CLK) begin
      shift_q <= shift_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!empty) state_d = START;
         START:   if (baud_end) state_d = DATA;
         DATA:    if (baud_end && (bit_q == 3'd7)) state_d = STOP;
         STOP:    if (baud_end) state_d = empty ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: FIFO pop, baud/bit counters, shifter and next tx level
   always_comb begin
      pop     = 1'b0;
      baud_d  = baud_q + BAUD_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d = '0;
               bit_d  = 3'd0;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               // Chain straight into the next start bit with no idle gap
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
               end
            end
         end
         default: baud_d = '0;
      endcase
      // tx is registered from the upcoming state so the pin never glitches
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign tx        = tx_q;
   assign busy      = (state_q != IDLE) | ~empty;
   assign read_data = (memread && hit_status) ? {28'b0, ovf_q, full, empty, busy} : 32'b0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx. A line receiver decodes tx into bytes; a queue
// model of the FIFO predicts which stored bytes must appear on the line.
module tb_mmio_uart_tx;
   localparam int          CPB    = 4;
   localparam int          DEPTH  = 8;
   localparam logic [31:0] BASE   = 32'h0000_1000;
   localparam logic [29:0] BASE_W = BASE[31:2];

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] write_data = '0;
   logic        memread = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] read_data;
   logic        tx;
   logic        busy;

   mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .CLK(CLK), .reset(reset), .addr(addr), .write_data(write_data),
      .memread(memread), .memwrite(memwrite), .read_data(read_data),
      .tx(tx), .busy(busy)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference model: bytes accepted by the FIFO, in order, and bytes seen on the line
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   time        start_q[$];
   int         n_acc = 0;
   int         n_started = 0;
   bit         model_ovf = 1'b0;
   bit         mon_en = 1'b1;
   bit         mon_busy = 1'b0;

   // Line receiver: samples each bit in its middle, frames start on the first low sample
   initial begin : rx_mon
      logic [7:0] b;
      forever begin
         @(negedge CLK);
         if (mon_en && !reset && tx === 1'b0) begin
            mon_busy = 1'b1;
            n_started++;
            start_q.push_back($time);
            repeat (CPB/2) @(negedge CLK);
            chk("rx_start_bit", tx, 0);
            for (int j = 0; j < 8; j++) begin
               repeat (CPB) @(negedge CLK);
               b[j] = tx;
            end
            repeat (CPB) @(negedge CLK);
            chk("rx_stop_bit", tx, 1);
            rx_q.push_back(b);
            repeat (CPB - CPB/2 - 1) @(negedge CLK);
            mon_busy = 1'b0;
         end
      end
   end

   // Store; the bus stays driven until the next bus task. The model decides
   // acceptance from the occupancy (accepted minus frames already started).
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge CLK);
      addr = a; write_data = d; memwrite = 1'b1; memread = 1'b0;
      #1;
      if (a[31:2] == BASE_W) begin
         if (n_acc - n_started < DEPTH) begin
            exp_q.push_back(d[7:0]);
            n_acc++;
         end else begin
            model_ovf = 1'b1;
         end
      end else if (a[31:2] == BASE_W + 30'd1 && d[3]) begin
         model_ovf = 1'b0;
      end
   endtask

   task automatic bus_idle();
      @(negedge CLK);
      addr = '0; write_data = '0; memwrite = 1'b0; memread = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge CLK);
      addr = a; memread = 1'b1; memwrite = 1'b0;
      #1 d = read_data;
      memread = 1'b0; addr = '0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || mon_busy) && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      chk(tag, (n < 3000), 1);
   endtask

   task automatic cmp_stream(input string tag);
      chk({tag, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk(tag, rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
      start_q.delete();
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] rd;
      logic [31:0] a;
      logic [9:0]  frame;
      int          nb;
      int          zeros;

      // Reset state
      #1 reset = 1'b1;
      repeat (3) @(negedge CLK);
      bus_read(BASE + 4, rd);
      chk("status_in_reset", rd, 32'h2);
      @(negedge CLK);
      reset = 1'b0;
      bus_read(BASE + 4, rd);
      chk("status_after_reset", rd, 32'h2);
      chk("tx_idle", tx, 1);
      chk("busy_idle", busy, 0);

      // Single frame, exact waveform
      bus_write(BASE, 32'hA5);
      bus_idle();
      chk("a5_tx_before_start", tx, 1);
      chk("a5_busy_queued", busy, 1);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int c = 0; c < 10*CPB; c++) begin
         @(negedge CLK);
         chk("a5_wave", tx, frame[c/CPB]);
      end
      @(negedge CLK);
      chk("a5_busy_done", busy, 0);
      chk("a5_tx_done", tx, 1);
      wait_idle("a5_idle");
      cmp_stream("a5_rx");

      // Back-to-back frames
      bus_write(BASE, 32'h41);
      bus_write(BASE, 32'h42);
      bus_write(BASE, 32'h43);
      bus_idle();
      repeat (20) @(negedge CLK);
      bus_read(BASE + 4, rd);
      chk("b2b_status_f1", rd, 32'h1);
      repeat (36) @(negedge CLK);
      bus_read(BASE + 4, rd);
      chk("b2b_status_f2", rd, 32'h1);
      repeat (38) @(negedge CLK);
      bus_read(BASE + 4, rd);
      chk("b2b_status_f3", rd, 32'h3);
      wait_idle("b2b_idle");
      chk("b2b_frames", start_q.size(), 3);
      if (start_q.size() == 3) begin
         chk("b2b_gap12", 32'(start_q[1] - start_q[0]), 32'(10*CPB*10));
         chk("b2b_gap23", 32'(start_q[2] - start_q[1]), 32'(10*CPB*10));
      end
      cmp_stream("b2b_rx");

      // Overflow while the line is busy, then drain with pointer wrap
      bus_write(BASE, 32'h10);
      bus_idle();
      repeat (8) @(negedge CLK);
      for (int i = 0; i < 9; i++) bus_write(BASE, 32'h20 + i);
      bus_idle();
      bus_read(BASE + 4, rd);
      chk("ovf_status", rd, 32'hD);
      bus_write(BASE + 4, 32'h7);
      bus_idle();
      bus_read(BASE + 4, rd);
      chk("ovf_not_cleared", rd, 32'hD);
      bus_write(BASE + 4, 32'h8);
      bus_idle();
      bus_read(BASE + 4, rd);
      chk("ovf_cleared", rd, 32'h5);
      wait_idle("ovf_idle");
      cmp_stream("ovf_rx");

      // Decode: other addresses, loads, unaligned push
      bus_write(BASE + 8, 32'h55);
      bus_idle();
      bus_read(BASE + 8, rd);
      chk("other_load", rd, 0);
      bus_read(BASE, rd);
      chk("txdata_load", rd, 0);
      bus_read(BASE + 4, rd);
      chk("other_store_status", rd, 32'h2);
      @(negedge CLK);
      addr = BASE + 4; memread = 1'b0;
      #1 chk("status_no_memread", read_data, 0);
      repeat (50) @(negedge CLK);
      chk("other_no_frame", rx_q.size(), 0);
      @(negedge CLK);
      addr = BASE + 4; write_data = 32'h8; memwrite = 1'b1; memread = 1'b1;
      #1 chk("rd_wr_both", read_data, 32'h2);
      bus_write(BASE + 1, 32'h3C);
      bus_idle();
      wait_idle("unaligned_idle");
      cmp_stream("unaligned_rx");

      // Randomized bursts
      for (int r = 0; r < 6; r++) begin
         nb = $urandom_range(1, DEPTH + 2);
         for (int i = 0; i < nb; i++) begin
            a = BASE | 32'($urandom_range(0, 3));
            bus_write(a, $urandom);
            if ($urandom_range(0, 1) == 1) begin
               bus_idle();
               repeat ($urandom_range(0, 3)) @(negedge CLK);
            end
            if ($urandom_range(0, 3) == 0) begin
               bus_read(BASE + 12, rd);
               chk("rand_other_load", rd, 0);
            end
         end
         bus_idle();
         bus_read(BASE + 4, rd);
         chk("rand_ovf", rd[3], model_ovf);
         wait_idle("rand_idle");
         cmp_stream("rand_rx");
         bus_write(BASE + 4, 32'h8);
         bus_idle();
         bus_read(BASE + 4, rd);
         chk("rand_status_end", rd, 32'h2);
      end

      // Reset in the middle of data bit 3
      mon_en = 1'b0;
      bus_write(BASE, 32'h00);
      bus_idle();
      repeat (18) @(negedge CLK);
      chk("rst_tx_before", tx, 0);
      #1 reset = 1'b1;
      #1;
      chk("rst_tx_async", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_read_data", read_data, 0);
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      exp_q.delete();
      rx_q.delete();
      start_q.delete();
      n_acc = 0;
      n_started = 0;
      model_ovf = 1'b0;
      mon_en = 1'b1;
      bus_read(BASE + 4, rd);
      chk("rst_status", rd, 32'h2);
      zeros = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (tx !== 1'b1) zeros++;
      end
      chk("rst_no_frame", zeros, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
